tdm_mux_n: RTL and testbench

//  Parametrised N-channel, W-bit multiplexer with a registered, handshaked output.
//  Two modes: SELECT, where the source is chosen by sel; and SCAN, where the source is a

---
 rtl/tdm_mux_pkg.sv | 20 ++
 rtl/tdm_mux_ptr.sv | 37 +++
 rtl/tdm_mux_n.sv | 101 ++++++++++
 tb/tb_tdm_mux_n.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the N-channel TDM multiplexer: the mode encoding and
// the select-width helper.
package tdm_mux_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Width needed to index v channels; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_mux_ptr.sv
// Modulo-N round-robin pointer for SCAN mode: async reset to 0, advances on
// adv, wraps from N-1 back to 0 by explicit compare.
module tdm_mux_ptr
  import tdm_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  output logic [SELW-1:0] ptr
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/tdm_mux_n.sv
// N-channel, W-bit multiplexer with a registered valid/ready output stage.
// SELECT picks the source by sel; SCAN walks a round-robin pointer over all channels.
module tdm_mux_n
  import tdm_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  mode_e           mode_s;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] cur;
  logic            free;
  logic            adv;
  logic            cur_valid;
  logic            load;
  logic [W-1:0]    cur_data;
  logic [W-1:0]    ch_data [N];

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;

  for (genvar g = 0; g < N; g++) begin : g_split
    assign ch_data[g] = in_data[g*W +: W];
  end

  assign mode_s = mode_e'(mode);
  assign cur    = (mode_s == MODE_SCAN) ? ptr : sel;
  assign free   = !out_valid_q || out_ready;
  assign adv    = (mode_s == MODE_SCAN) && free;

  // Only an index in 0..N-1 can match, so cur >= N selects nothing.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    in_ready  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cur == SELW'(k)) begin
        cur_valid   = in_valid[k];
        cur_data    = ch_data[k];
        in_ready[k] = free && !rst;
      end
    end
  end

  assign load = free && cur_valid;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (free) begin
      out_valid_d = load;
      if (load) begin
        out_data_d = cur_data;
        out_ch_d   = cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  tdm_mux_ptr #(
    .N    (N),
    .SELW (SELW)
  ) u_ptr (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .ptr (ptr)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_tdm_mux_n.sv
// Directed bench for tdm_mux_n: a 4-channel and a 3-channel instance driven
// from a vector table, plus a hand-written mid-stream reset sequence.
module tb_tdm_mux_n;

  logic clk;
  logic rst;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic        mode4, out_valid4, out_ready4;
  logic [1:0]  sel4, out_ch4;
  logic [7:0]  out_data4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3, out_valid3, out_ready3;
  logic [1:0]  sel3, out_ch3;
  logic [7:0]  out_data3;

  int n_chk  = 0;
  int n_fail = 0;

  tdm_mux_n #(.N(4), .W(8)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
    .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  tdm_mux_n #(.N(3), .W(8)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        dut;     // 0 = N4 instance, 1 = N3 instance
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] din;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic d, input logic m, input logic [1:0] s,
                     input logic [3:0] iv, input logic [31:0] din, input logic ordy,
                     input logic [3:0] ir, input logic ov, input logic [7:0] od,
                     input logic [1:0] ch);
    vec_t v;
    v.dut = d; v.mode = m; v.sel = s; v.iv = iv; v.din = din; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_ch = ch;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    if (v.dut == 1'b0) begin
      mode4 = v.mode; sel4 = v.sel; in_valid4 = v.iv; in_data4 = v.din; out_ready4 = v.ordy;
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    end else begin
      mode3 = v.mode; sel3 = v.sel; in_valid3 = v.iv[2:0]; in_data3 = v.din[23:0];
      out_ready3 = v.ordy;
      mode4 = 1'b0; sel4 = 2'd0; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    end
  endtask

  // Per-cycle invariants: one-hot-or-zero in_ready, outputs frozen across a stall.
  logic       st4, st3;
  logic [7:0] pd4, pd3;
  logic [1:0] pc4, pc3;

  always @(negedge clk) begin
    chk("onehot u4", 32'($onehot0(in_ready4)), 32'd1);
    if (rst) begin
      st4 = 1'b0;
    end else begin
      if (st4) begin
        chk("stall valid u4", 32'(out_valid4), 32'd1);
        chk("stall data u4", 32'(out_data4), 32'(pd4));
        chk("stall ch u4", 32'(out_ch4), 32'(pc4));
      end
      st4 = out_valid4 && !out_ready4;
      pd4 = out_data4;
      pc4 = out_ch4;
    end
  end

  always @(negedge clk) begin
    chk("onehot u3", 32'($onehot0(in_ready3)), 32'd1);
    if (rst) begin
      st3 = 1'b0;
    end else begin
      if (st3) begin
        chk("stall valid u3", 32'(out_valid3), 32'd1);
        chk("stall data u3", 32'(out_data3), 32'(pd3));
        chk("stall ch u3", 32'(out_ch3), 32'(pc3));
      end
      st3 = out_valid3 && !out_ready3;
      pd3 = out_data3;
      pc3 = out_ch3;
    end
  end

  localparam logic [31:0] D = 32'h13121110;

  initial begin
    rst = 1'b1;
    mode4 = 1'b0; sel4 = 2'd0; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;

    // SELECT sel=2
    add(0, 0, 2, 4'b0100, 32'h13A51110, 1, 4'b0100, 1, 8'hA5, 2);
    // SELECT sel=1, then three stalled clocks, then release with new data
    add(0, 0, 1, 4'b0010, D,            1, 4'b0010, 1, 8'h11, 1);
    add(0, 0, 1, 4'b0010, 32'h13125510, 0, 4'b0000, 1, 8'h11, 1);
    add(0, 0, 1, 4'b0010, 32'h13125510, 0, 4'b0000, 1, 8'h11, 1);
    add(0, 0, 1, 4'b0010, 32'h13125510, 0, 4'b0000, 1, 8'h11, 1);
    add(0, 0, 1, 4'b0010, 32'h13125510, 1, 4'b0010, 1, 8'h55, 1);
    add(0, 0, 1, 4'b0000, D,            1, 4'b0010, 0, 8'h00, 0);
    // SCAN, all channels valid: two full rotations
    add(0, 1, 0, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3);
    // SCAN with idle channels 0 and 2
    add(0, 1, 0, 4'b1010, D, 1, 4'b0001, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1010, D, 1, 4'b0010, 1, 8'h11, 1);
    add(0, 1, 0, 4'b1010, D, 1, 4'b0100, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1010, D, 1, 4'b1000, 1, 8'h13, 3);
    add(0, 1, 0, 4'b1010, D, 1, 4'b0001, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1010, D, 1, 4'b0010, 1, 8'h11, 1);
    // SCAN stall: pointer holds its slot
    add(0, 1, 0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 0, 4'b0000, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 0, 4'b0000, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3);
    // Mode switch: SELECT leaves ptr at 0, SCAN resumes there
    add(0, 0, 2, 4'b0100, D, 1, 4'b0100, 1, 8'h12, 2);
    add(0, 0, 2, 4'b0100, D, 1, 4'b0100, 1, 8'h12, 2);
    add(0, 1, 0, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0);
    // N=3: SCAN wrap 2->0, SELECT sel=3 selects nothing
    add(1, 1, 0, 4'b0111, 32'h00121110, 1, 4'b0001, 1, 8'h10, 0);
    add(1, 1, 0, 4'b0111, 32'h00121110, 1, 4'b0010, 1, 8'h11, 1);
    add(1, 1, 0, 4'b0111, 32'h00121110, 1, 4'b0100, 1, 8'h12, 2);
    add(1, 1, 0, 4'b0111, 32'h00121110, 1, 4'b0001, 1, 8'h10, 0);
    add(1, 0, 3, 4'b0111, 32'h00121110, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 0, 3, 4'b0111, 32'h00121110, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 0, 2, 4'b0111, 32'h00121110, 1, 4'b0100, 1, 8'h12, 2);
    add(1, 1, 0, 4'b0111, 32'h00121110, 1, 4'b0010, 1, 8'h11, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid u4", 32'(out_valid4), 32'd0);
    chk("reset out_data u4", 32'(out_data4), 32'd0);
    chk("reset out_ch u4", 32'(out_ch4), 32'd0);
    chk("reset in_ready u4", 32'(in_ready4), 32'd0);
    chk("reset out_valid u3", 32'(out_valid3), 32'd0);
    chk("reset in_ready u3", 32'(in_ready3), 32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      apply(vq[i]);
      #1;
      if (vq[i].dut) chk($sformatf("v%0d in_ready", i), 32'(in_ready3), 32'(vq[i].exp_ir));
      else           chk($sformatf("v%0d in_ready", i), 32'(in_ready4), 32'(vq[i].exp_ir));
      @(posedge clk);
      #1;
      if (vq[i].dut) begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid3), 32'(vq[i].exp_ov));
        if (vq[i].exp_ov) begin
          chk($sformatf("v%0d out_data", i), 32'(out_data3), 32'(vq[i].exp_od));
          chk($sformatf("v%0d out_ch", i), 32'(out_ch3), 32'(vq[i].exp_ch));
        end
      end else begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid4), 32'(vq[i].exp_ov));
        if (vq[i].exp_ov) begin
          chk($sformatf("v%0d out_data", i), 32'(out_data4), 32'(vq[i].exp_od));
          chk($sformatf("v%0d out_ch", i), 32'(out_ch4), 32'(vq[i].exp_ch));
        end
      end
    end

    // Mid-stream reset while the output is stalled (u4 ptr is 1 here)
    mode4 = 1'b1; sel4 = 2'd0; in_valid4 = 4'b1111; in_data4 = D; out_ready4 = 1'b1;
    #1;
    chk("rst seq in_ready", 32'(in_ready4), 32'b0010);
    @(posedge clk);
    #1;
    chk("rst seq load ch", 32'(out_ch4), 32'd1);
    out_ready4 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst seq stalled", 32'(out_valid4), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid4), 32'd0);
    chk("async rst out_data", 32'(out_data4), 32'd0);
    chk("async rst out_ch", 32'(out_ch4), 32'd0);
    chk("async rst in_ready", 32'(in_ready4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready4 = 1'b1;
    #1;
    chk("post rst in_ready", 32'(in_ready4), 32'b0001);
    @(posedge clk);
    #1;
    chk("post rst out_valid", 32'(out_valid4), 32'd1);
    chk("post rst out_data", 32'(out_data4), 32'h10);
    chk("post rst out_ch", 32'(out_ch4), 32'd0);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
